div5seq: RTL and testbench

DIV5SEQ -- requirements
Module: div5seq

---
 rtl/div5_pkg.sv | 12 +
 rtl/div5_step.sv | 19 +
 rtl/div5seq.sv | 98 +++++++++
 tb/tb_div5seq.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/div5_pkg.sv
// Shared definitions for the sequential restoring divider.
package div5_pkg;

    localparam int DEF_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div5_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div5_step #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             din,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH:0]   rem_out,
    output logic             qbit
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_in[WIDTH-1:0], din};
    // A set top bit means the shifted value already exceeds any divisor.
    assign qbit    = rem_in[WIDTH] | (shifted >= {1'b0, div});
    assign rem_out = qbit ? (shifted - {1'b0, div}) : shifted;

endmodule

// File: rtl/div5seq.sv
// Sequential unsigned divider, one quotient bit per clock, MSB first, valid/ready on both sides.
module div5seq
    import div5_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] aa,
    input  logic [WIDTH-1:0] bb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] qq,
    output logic [WIDTH-1:0] rr,
    output logic             dbz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, quo_q, quo_nxt;
    logic [WIDTH:0]   rem_q, rem_nxt;
    logic [CW-1:0]    cnt_q;
    logic             qbit, accept;

    div5_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .din     (a_q[WIDTH-1]),
        .div     (b_q),
        .rem_out (rem_nxt),
        .qbit    (qbit)
    );

    assign quo_nxt = (quo_q << 1) | WIDTH'(qbit);
    assign accept  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = (bb == '0) ? DONE : CALC;
            end
            CALC: if (cnt_q == LAST) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            quo_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            qq    <= '0;
            rr    <= '0;
            dbz   <= 1'b0;
        end else if (accept) begin
            a_q   <= aa;
            b_q   <= bb;
            quo_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            // Divide-by-zero skips the iterations and reports immediately.
            if (bb == '0) begin
                qq  <= '1;
                rr  <= aa;
                dbz <= 1'b1;
            end
        end else if (state_q == CALC) begin
            a_q   <= a_q << 1;
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                qq  <= quo_nxt;
                rr  <= rem_nxt[WIDTH-1:0];
                dbz <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div5seq.sv
// Randomized and directed checks of div5seq against an arithmetic reference.
module tb_div5seq;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] aa = '0;
    logic [W-1:0] bb = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] qq, rr;
    logic         dbz;

    int checks = 0;
    int errors = 0;

    div5seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aa        (aa),
        .bb        (bb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .qq        (qq),
        .rr        (rr),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, divide-by-zero yields all ones / dividend.
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << W) - 1;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // Latency is counted in rising edges, the accepting edge being the first.
    task automatic do_div(input int a, input int b, input int stall);
        int q, r, z, lat, exp_lat;
        ref_div(a, b, q, r, z);
        exp_lat = (b == 0) ? 1 : W + 1;
        chk("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        aa        = W'(a);
        bb        = W'(b);
        out_ready = (stall == 0);
        @(posedge clk); #1;
        lat = 1;
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom);
            aa = W'($urandom);
            bb = W'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("qq", qq, q);
        chk("rr", rr, r);
        chk("dbz", dbz, z);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            aa = W'($urandom);
            bb = W'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_qq", qq, q);
            chk("hold_rr", rr, r);
            chk("hold_dbz", dbz, z);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_qq", qq, 0);
        chk("rst_rr", rr, 0);
        chk("rst_dbz", dbz, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_div(23, 4, 0);
        do_div(31, 1, 0);
        do_div(3, 9, 0);
        do_div(7, 0, 0);
        do_div(29, 6, 10);

        // Reset in the middle of a division aborts it.
        in_valid = 1'b1;
        aa = W'(27);
        bb = W'(3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_qq", qq, 0);
        chk("abort_rr", rr, 0);
        @(posedge clk); #1;
        chk("abort_no_result", out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_div(20, 5, 0);

        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++)
                do_div(a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
